// File: rtl/pll_lock_supervisor_if.sv
// ============================================================================
// Module : pll_lock_supervisor_if
// Desc   : PLL lock supervisor control/status bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface pll_lock_supervisor_if;
  logic       locked_in;
  logic       clear_fail;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  // master = the supervisor, slave = the PLL/system side around it
  modport master (
    input  locked_in, clear_fail,
    output pll_rst, sys_rst_n, ready, fail, retry_count, lock_loss_count
  );

  modport slave (
    output locked_in, clear_fail,
    input  pll_rst, sys_rst_n, ready, fail, retry_count, lock_loss_count
  );
endinterface

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module : pll_lock_supervisor
// Desc   : PLL reset/lock handshake with retry, stable-lock release, loss count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pll_lock_supervisor_if.master bus
);

  localparam int c_MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int c_MAX_CYC = (c_MAX_A > STABLE_CYCLES) ? c_MAX_A : STABLE_CYCLES;
  localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

  localparam logic [c_CNT_W-1:0] c_RST_LAST = c_CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_STB_LAST = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]         c_MAX_RTY  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sync1;
  logic               r_lock_s;
  logic [3:0]         r_retry;
  logic [3:0]         w_retry_next;
  logic [7:0]         r_llc;
  logic [7:0]         w_llc_next;
  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_ready;
  logic               r_fail;

  // locked_in is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= bus.locked_in;
      r_lock_s <= r_sync1;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_retry_next = r_retry;
    w_llc_next   = r_llc;
    case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == c_RST_LAST) w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (r_lock_s) begin
          w_next = S_STABLE;
        end else if (r_cnt == c_TO_LAST) begin
          if (r_retry == c_MAX_RTY) begin
            w_next = S_FAIL;
          end else begin
            w_retry_next = r_retry + 4'd1;
            w_next       = S_RESET_PLL;
          end
        end
      end
      S_STABLE: begin
        if (!r_lock_s)                w_next = S_WAIT_LOCK;
        else if (r_cnt == c_STB_LAST) w_next = S_RUN;
      end
      S_RUN: begin
        if (!r_lock_s) begin
          if (r_llc != 8'hFF) w_llc_next = r_llc + 8'd1;
          w_retry_next = 4'd0;
          w_next       = S_RESET_PLL;
        end
      end
      S_FAIL: begin
        if (bus.clear_fail) begin
          w_retry_next = 4'd0;
          w_next       = S_RESET_PLL;
        end
      end
      default: w_next = S_RESET_PLL;
    endcase
  end

  // Outputs are decoded from the next state so they move with the state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_retry     <= 4'd0;
      r_llc       <= 8'd0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (w_next != r_state) ? '0 : r_cnt + c_CNT_W'(1);
      r_retry     <= w_retry_next;
      r_llc       <= w_llc_next;
      r_pll_rst   <= (w_next == S_RESET_PLL) || (w_next == S_FAIL);
      r_sys_rst_n <= (w_next == S_RUN);
      r_ready     <= (w_next == S_RUN);
      r_fail      <= (w_next == S_FAIL);
    end
  end

  assign bus.pll_rst         = r_pll_rst;
  assign bus.sys_rst_n       = r_sys_rst_n;
  assign bus.ready           = r_ready;
  assign bus.fail            = r_fail;
  assign bus.retry_count     = r_retry;
  assign bus.lock_loss_count = r_llc;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// Module : tb_pll_lock_supervisor
// Desc   : Directed vector table plus corner-case sequences for the supervisor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic rst;
    logic lock;
    logic clr;
    logic pll;
    logic sys;
    logic rdy;
    logic fl;
    int   rc;
    int   llc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int n, input logic rst, input logic lock, input logic clr,
                              input logic pll, input logic sys, input logic rdy, input logic fl,
                              input int rc, input int llc);
    vec_t v;
    v.n = n; v.rst = rst; v.lock = lock; v.clr = clr;
    v.pll = pll; v.sys = sys; v.rdy = rdy; v.fl = fl; v.rc = rc; v.llc = llc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".pll_rst"},         32'(bus.pll_rst),         32'(v.pll));
    chk({tag, ".sys_rst_n"},       32'(bus.sys_rst_n),       32'(v.sys));
    chk({tag, ".ready"},           32'(bus.ready),           32'(v.rdy));
    chk({tag, ".fail"},            32'(bus.fail),            32'(v.fl));
    chk({tag, ".retry_count"},     32'(bus.retry_count),     32'(v.rc));
    chk({tag, ".lock_loss_count"}, 32'(bus.lock_loss_count), 32'(v.llc));
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.locked_in  = 1'b0;
    bus.clear_fail = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int c;
    c = 0;
    while (bus.ready !== 1'b1 && c < budget) begin
      step();
      c++;
    end
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: ready got %0d expected 1 within %0d cycles", tag, bus.ready, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.locked_in  = 1'b0;
    bus.clear_fail = 1'b0;

    //              n  rst lk clr pll sys rdy fl rc llc
    // reset, clean lock, lock loss in RUN
    tbl.push_back(mk( 3, 1, 0, 0,  1,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 3, 0, 0, 0,  1,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 5, 0, 0, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 9, 0, 1, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0,  0,  1,  1, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 0,  0,  1,  1, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0,  0,  1,  1, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 1, 0,  1,  0,  0, 0, 0, 1));
    tbl.push_back(mk( 3, 0, 1, 0,  1,  0,  0, 0, 0, 1));
    tbl.push_back(mk( 1, 0, 1, 0,  0,  0,  0, 0, 0, 1));
    tbl.push_back(mk( 8, 0, 1, 0,  0,  0,  0, 0, 0, 1));
    tbl.push_back(mk( 1, 0, 1, 0,  0,  1,  1, 0, 0, 1));
    // never lock: three attempts, FAIL, then clear_fail
    tbl.push_back(mk( 2, 1, 0, 0,  1,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 4, 0, 0, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(19, 0, 0, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 0,  1,  0,  0, 0, 1, 0));
    tbl.push_back(mk( 3, 0, 0, 0,  1,  0,  0, 0, 1, 0));
    tbl.push_back(mk( 1, 0, 0, 0,  0,  0,  0, 0, 1, 0));
    tbl.push_back(mk(19, 0, 0, 0,  0,  0,  0, 0, 1, 0));
    tbl.push_back(mk( 1, 0, 0, 0,  1,  0,  0, 0, 2, 0));
    tbl.push_back(mk( 4, 0, 0, 0,  0,  0,  0, 0, 2, 0));
    tbl.push_back(mk(19, 0, 0, 0,  0,  0,  0, 0, 2, 0));
    tbl.push_back(mk( 1, 0, 0, 0,  1,  0,  0, 1, 2, 0));
    tbl.push_back(mk( 5, 0, 0, 0,  1,  0,  0, 1, 2, 0));
    tbl.push_back(mk( 1, 0, 0, 1,  1,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 3, 0, 0, 0,  1,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 0,  0,  0,  0, 0, 0, 0));
    tbl.push_back(mk( 1, 0, 0, 1,  0,  0,  0, 0, 0, 0));

    foreach (tbl[i]) begin
      rst_n          = !tbl[i].rst;
      bus.locked_in  = tbl[i].lock;
      bus.clear_fail = tbl[i].clr;
      for (int c = 0; c < tbl[i].n; c++) begin
        step();
        bus.clear_fail = 1'b0;
      end
      chk_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Glitchy lock: 5 cycles of lock, 3-cycle dropout, then a full fresh stable window
    do_reset();
    repeat (4) step();
    bus.locked_in = 1'b1;
    repeat (5) step();
    bus.locked_in = 1'b0;
    repeat (3) step();
    chk("glitch.pll_rst_low", 32'(bus.pll_rst), 32'd0);
    bus.locked_in = 1'b1;
    repeat (10) step();
    chk("glitch.ready_early", 32'(bus.ready), 32'd0);
    chk("glitch.retry",       32'(bus.retry_count), 32'd0);
    step();
    chk("glitch.ready",     32'(bus.ready), 32'd1);
    chk("glitch.sys_rst_n", 32'(bus.sys_rst_n), 32'd1);

    // Repeated single-cycle lock loss in RUN: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      bus.locked_in = 1'b0;
      step();
      bus.locked_in = 1'b1;
      step();
      step();
      chk($sformatf("loss%0d.sys_rst_n", i), 32'(bus.sys_rst_n), 32'd0);
      chk($sformatf("loss%0d.llc", i), 32'(bus.lock_loss_count), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      wait_ready($sformatf("loss%0d.relock", i), 40);
    end
    chk("sat.pll_rst", 32'(bus.pll_rst), 32'd0);

    // Asynchronous reset between edges while in RUN
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    chk("arst.pll_rst",   32'(bus.pll_rst), 32'd1);
    chk("arst.ready",     32'(bus.ready), 32'd0);
    chk("arst.llc",       32'(bus.lock_loss_count), 32'd0);
    chk("arst.retry",     32'(bus.retry_count), 32'd0);

    // lock_s rises in the same cycle the lock timeout would fire
    do_reset();
    repeat (21) step();
    bus.locked_in = 1'b1;
    repeat (3) step();
    chk("simul.pll_rst", 32'(bus.pll_rst), 32'd0);
    chk("simul.retry",   32'(bus.retry_count), 32'd0);
    repeat (7) step();
    chk("simul.ready_early", 32'(bus.ready), 32'd0);
    step();
    chk("simul.ready", 32'(bus.ready), 32'd1);
    chk("simul.retry_run", 32'(bus.retry_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
